or_lane_scheduler: RTL and testbench
====================================

// Module: or_lane_scheduler
// PURPOSE
//   Time-shares one 1-bit OR lane cell (o = i1 ? i1 : i2) among NREQ requesters.
//   Each requester submits a WIDTH-bit operand pair; the block arbitrates round-robin, then feeds the pair bit-serially through the single shared cell.
//   It assembles the result word and returns it, tagged with the requester id.
//   Sits between the per-lane operand sources and the consumer of the OR results.
// PARAMETERS
//   NREQ   4  number of requesters (>=2)
//   WIDTH  6  operand/result width in bits (>=1)
//   IDW    $clog2(NREQ)  requester id width (derived, localparam)
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        per-requester accept (one-hot or zero)
//   req_a      in   NREQ*WIDTH  operand A, requester r at [r*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   rsp_valid  out  1           result valid
//   rsp_ready  in   1           consumer accepts result
//   rsp_id     out  IDW         id of requester that owns rsp_data
//   rsp_data   out  WIDTH       rsp_data[k] = a[k] | b[k]
//   busy       out  1           high in RUN or DONE
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0; busy=0.
//     - bit counter=0; rr pointer=NREQ-1, so requester 0 wins first.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     - If any req_valid, grant = first valid at or after (ptr+1) mod NREQ.
//     - req_ready[grant]=1 combinationally this cycle; all other bits 0.
//     - Latch a/b of grant and grant id; ptr<=grant; cnt<=0; go RUN.
//     - req_ready is 0 in every other state.
//   RUN:
//     - Each cycle: drive cell i1=a_q[cnt], i2=b_q[cnt]; res_q[cnt] <= cell output.
//     - cnt increments; after the cycle with cnt==WIDTH-1, go DONE.
//     - Exactly WIDTH RUN cycles.
//   DONE:
//     - rsp_valid=1; rsp_id/rsp_data stable until rsp_ready sampled high.
//     - On rsp_valid&&rsp_ready, go IDLE.
//   Latency and throughput:
//     - Accept at cycle T -> rsp_valid first high at T+WIDTH+1.
//     - At most one transaction per WIDTH+2 cycles with rsp_ready tied high.
//   Boundary cases:
//     - No req_valid in IDLE: stay IDLE; ptr unchanged.
//     - req_valid dropped by a requester while it is not granted: no effect; no request is lost or held internally.
//     - Request asserted during RUN/DONE: not accepted until next IDLE. It wins that IDLE cycle if first in round-robin order.
//     - rsp_ready held low: DONE holds indefinitely; no new grants.
//     - ptr wraps from NREQ-1 to 0; single active requester is re-granted each IDLE.
//     - rsp_ready high outside DONE: ignored.
//     - rst_n asserted mid-RUN/DONE: transaction discarded, all state to reset values, no response issued.
//   Width rules: cnt is $clog2(WIDTH+1) bits; no arithmetic beyond increment and modulo-NREQ pointer wrap.
// STRUCTURE
//   Package or_lane_pkg:
//     - state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2}
//     - default NREQ/WIDTH constants.
//   Sub-module or_lane_cell (i1, i2 -> o1, o1 = i1 ? i1 : i2):
//     - The shared resource; instantiated exactly once.
//   Round-robin pick is a combinational function in the top module.
// TESTING
//   1 Single req: r2 a=6'b101010 b=6'b000111 at T.
//     -> req_ready=4'b0100 at T; rsp_valid at T+7, id=2, data=6'b101111.
//   2 All four valid continuously, rsp_ready=1 from reset.
//     -> grant order 0,1,2,3,0; rsp_id sequence 0,1,2,3,0.
//   3 rsp_ready low 10 cycles in DONE, r1 pending.
//     -> rsp_valid/data stable; req_ready=0 throughout; r1 granted in IDLE after handshake.
//   4 rst_n low at the 3rd RUN cycle of r0 (a=6'h3F).
//     -> immediately rsp_valid=0, busy=0; after release, r0 granted first again.
//   5 Corner operands: a=b=0 -> data=0; a=0 b=6'h3F -> 6'h3F; a=6'h15 b=6'h2A -> 6'h3F.
//   6 Only r3 valid, repeated 3 times.
//     -> granted every IDLE, ptr stays 3, one rsp per 8 cycles.

Source files
------------

// File: rtl/or_lane_pkg.sv
// rtl/or_lane_pkg.sv - shared types and defaults for the OR lane scheduler
package or_lane_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 6;

endpackage

// File: rtl/or_lane_cell.sv
// rtl/or_lane_cell.sv - the single shared 1-bit OR cell
module or_lane_cell (
   input  logic i1,
   input  logic i2,
   output logic o1
);

   assign o1 = i1 ? i1 : i2;

endmodule

// File: rtl/or_lane_scheduler.sv
// rtl/or_lane_scheduler.sv - round-robin scheduler feeding operand pairs bit-serially through one OR cell
module or_lane_scheduler
   import or_lane_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*WIDTH-1:0]     req_a,
   input  logic [NREQ*WIDTH-1:0]     req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]          rsp_data,
   output logic                      busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(WIDTH + 1);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_t           state, state_n;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant;
   logic [IDW-1:0]   id_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic             cell_i1, cell_i2, cell_o;

   // First valid requester strictly after ptr, wrapping modulo NREQ.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  p);
      logic [IDW-1:0] idx;
      logic [IDW-1:0] sel;
      logic           found;
      idx   = p;
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (idx == LAST_ID) ? '0 : idx + 1'b1;
         if (!found && v[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign grant = rr_pick(req_valid, ptr);

   assign cell_i1 = a_q[cnt];
   assign cell_i2 = b_q[cnt];

   or_lane_cell u_cell (
      .i1 (cell_i1),
      .i2 (cell_i2),
      .o1 (cell_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               req_ready[grant] = 1'b1;
               state_n          = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_BIT) state_n = DONE;
         end
         DONE: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= LAST_ID;
         id_q  <= '0;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  a_q  <= req_a[grant*WIDTH +: WIDTH];
                  b_q  <= req_b[grant*WIDTH +: WIDTH];
                  id_q <= grant;
                  ptr  <= grant;
                  cnt  <= '0;
               end
            end
            RUN: begin
               res_q[cnt] <= cell_o;
               cnt        <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign rsp_id    = id_q;
   assign rsp_data  = res_q;

endmodule

// File: tb/tb_or_lane_scheduler.sv
// tb/tb_or_lane_scheduler.sv - randomized self-checking bench with a transaction-level reference model
module tb_or_lane_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 6;
   localparam int IDW   = $clog2(NREQ);

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  busy;

   or_lane_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: one outstanding transaction, response due WIDTH+1 cycles after accept.
   int               cyc    = 0;
   int               m_ptr  = NREQ - 1;
   logic             m_busy = 1'b0;
   int               m_acc  = 0;
   int               m_id   = 0;
   logic [WIDTH-1:0] m_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                       input logic [NREQ*WIDTH-1:0] b, input logic rr);
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic            exp_rv;
      @(negedge clk);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rr;
      #1;
      g       = -1;
      exp_rdy = '0;
      if (!m_busy) begin
         for (int k = 1; k <= NREQ; k++) begin
            automatic int idx = (m_ptr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
      end
      exp_rv = m_busy && (cyc >= m_acc + WIDTH + 1);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
      end
      if (!m_busy && g >= 0) begin
         m_busy = 1'b1;
         m_acc  = cyc;
         m_ptr  = g;
         m_id   = g;
         m_data = a[g*WIDTH +: WIDTH] | b[g*WIDTH +: WIDTH];
      end else if (exp_rv && rr) begin
         m_busy = 1'b0;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'($urandom);
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      m_busy = 1'b0;
      m_ptr  = NREQ - 1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [NREQ*WIDTH-1:0] lane(input int r, input logic [WIDTH-1:0] val);
      logic [NREQ*WIDTH-1:0] w;
      w = '0;
      w[r*WIDTH +: WIDTH] = val;
      return w;
   endfunction

   function automatic logic [NREQ*WIDTH-1:0] rnd_ops();
      logic [NREQ*WIDTH-1:0] w;
      for (int r = 0; r < NREQ; r++) w[r*WIDTH +: WIDTH] = WIDTH'($urandom);
      return w;
   endfunction

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      do_reset();

      // single request from r2
      step(4'b0100, lane(2, 6'b101010), lane(2, 6'b000111), 1'b1);
      for (int i = 0; i < 9; i++) step('0, '0, '0, 1'b1);

      // all requesters valid with rsp_ready high: grants rotate 0,1,2,3,0
      for (int i = 0; i < 5 * (WIDTH + 2); i++) step('1, rnd_ops(), rnd_ops(), 1'b1);
      while (m_busy && cyc < 1000) step('0, '0, '0, 1'b1);

      // consumer stalls 10 cycles in DONE while r1 waits
      step(4'b0001, lane(0, 6'h15), lane(0, 6'h2A), 1'b0);
      for (int i = 0; i < WIDTH + 10; i++) step(4'b0010, lane(1, 6'h01), lane(1, 6'h20), 1'b0);
      for (int i = 0; i < WIDTH + 4; i++) step(4'b0010, lane(1, 6'h01), lane(1, 6'h20), 1'b1);
      while (m_busy && cyc < 1000) step('0, '0, '0, 1'b1);

      // reset during the third RUN cycle of r0, then r0 wins first again
      step(4'b0001, lane(0, 6'h3F), lane(0, 6'h00), 1'b1);
      step('0, '0, '0, 1'b1);
      step('0, '0, '0, 1'b1);
      do_reset();
      for (int i = 0; i < WIDTH + 3; i++) step('1, rnd_ops(), rnd_ops(), 1'b1);
      while (m_busy && cyc < 2000) step('0, '0, '0, 1'b1);

      // corner operands through r1
      step(4'b0010, '0, '0, 1'b1);
      for (int i = 0; i < WIDTH + 1; i++) step('0, '0, '0, 1'b1);
      step(4'b0010, lane(1, 6'h00), lane(1, 6'h3F), 1'b1);
      for (int i = 0; i < WIDTH + 1; i++) step('0, '0, '0, 1'b1);
      step(4'b0010, lane(1, 6'h15), lane(1, 6'h2A), 1'b1);
      for (int i = 0; i < WIDTH + 1; i++) step('0, '0, '0, 1'b1);

      // only r3 valid: re-granted every IDLE
      for (int i = 0; i < 3 * (WIDTH + 2); i++) step(4'b1000, rnd_ops(), rnd_ops(), 1'b1);
      while (m_busy && cyc < 3000) step('0, '0, '0, 1'b1);

      // randomized traffic with stalls and occasional resets
      for (int i = 0; i < 1500; i++) begin
         logic [NREQ-1:0] v;
         logic            rr;
         v  = NREQ'($urandom) & NREQ'($urandom | $urandom);
         rr = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) do_reset();
         else step(v, rnd_ops(), rnd_ops(), rr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
